sram_responder: RTL and testbench

Memory-side responder for the LC-3 SRAM interface. It sits on the far end of the processor's ADDR, CE, UB, LB, OE, WE and bidirectional data bus and behaves as a word-organised SRAM with byte lanes and a programmable number of wait states. It decodes the processor's active-low strobes, services one read or write per strobe assertion, and drives the shared bus only while a read is being returned. It is used as the on-chip memory model for lab bring-up and as the golden memory in processor testbenches.

---
 rtl/sram_responder.sv | 149 ++++++++++++++
 tb/tb_sram_responder.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_responder.sv
// Word-organised SRAM responder with byte lanes and programmable wait states.
// Services one access per strobe assertion and drives Data only while returning a read.
module sram_responder #(
    parameter int ADDR_W      = 8,
    parameter int WAIT_STATES = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [15:0] ADDR,
    inout  wire  [15:0] Data,
    input  logic        CE,
    input  logic        OE,
    input  logic        WE,
    input  logic        UB,
    input  logic        LB,
    output logic        R,
    output logic        Busy
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int CW    = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RDONE,
        S_WDONE
    } state_t;

    state_t              state_q;
    logic [CW-1:0]       cnt_q;
    logic [ADDR_W-1:0]   addr_q;
    logic                ub_q;
    logic                lb_q;
    logic                wr_q;
    logic [15:0]         wdata_q;
    logic [15:0]         dout_q;
    logic                oe_q;
    logic                r_q;
    logic                busy_q;

    logic [15:0]         mem [DEPTH];

    logic                start;
    logic                strobe_off;
    logic [CW-1:0]       cnt_d;
    logic [ADDR_W-1:0]   acc_addr;
    logic                acc_ub;
    logic                acc_lb;
    logic [15:0]         rd_word;
    logic [15:0]         rd_lanes;
    logic                unused_addr;

    assign unused_addr = ^{ADDR, 1'b0};

    assign start      = !CE && (!WE || !OE);
    assign strobe_off = CE || (wr_q ? WE : OE);
    assign cnt_d      = cnt_q - CW'(1);

    // A zero-wait read completes from IDLE, so it must see the live request.
    assign acc_addr = (state_q == S_IDLE) ? ADDR[ADDR_W-1:0] : addr_q;
    assign acc_ub   = (state_q == S_IDLE) ? UB : ub_q;
    assign acc_lb   = (state_q == S_IDLE) ? LB : lb_q;
    assign rd_word  = mem[acc_addr];
    assign rd_lanes = {acc_ub ? 8'h00 : rd_word[15:8],
                       acc_lb ? 8'h00 : rd_word[7:0]};

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            ub_q    <= 1'b1;
            lb_q    <= 1'b1;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            dout_q  <= '0;
            oe_q    <= 1'b0;
            r_q     <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            r_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        addr_q  <= ADDR[ADDR_W-1:0];
                        ub_q    <= UB;
                        lb_q    <= LB;
                        wr_q    <= !WE;
                        wdata_q <= Data;
                        busy_q  <= 1'b1;
                        if (WAIT_STATES == 0) begin
                            r_q <= 1'b1;
                            if (!WE) begin
                                state_q <= S_WDONE;
                            end else begin
                                state_q <= S_RDONE;
                                dout_q  <= rd_lanes;
                                oe_q    <= 1'b1;
                            end
                        end else begin
                            cnt_q   <= CW'(WAIT_STATES);
                            state_q <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (strobe_off) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_d;
                        if (cnt_d == '0) begin
                            r_q <= 1'b1;
                            if (wr_q) begin
                                state_q <= S_WDONE;
                            end else begin
                                state_q <= S_RDONE;
                                dout_q  <= rd_lanes;
                                oe_q    <= 1'b1;
                            end
                        end
                    end
                end
                S_RDONE, S_WDONE: begin
                    if (strobe_off) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        oe_q    <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Commit at the edge closing the first WDONE cycle; reset clears r_q first.
    always_ff @(posedge Clk) begin
        if (state_q == S_WDONE && r_q) begin
            if (!ub_q) mem[addr_q][15:8] <= wdata_q[15:8];
            if (!lb_q) mem[addr_q][7:0]  <= wdata_q[7:0];
        end
    end

    assign Data = oe_q ? dout_q : 16'hzzzz;
    assign R    = r_q;
    assign Busy = busy_q;

endmodule

// File: tb/tb_sram_responder.sv
// Bench for sram_responder: two instances (2 and 0 wait states) share the strobes,
// checked against constant vectors and a lane-level memory model.
module tb_sram_responder;

    logic        Clk;
    logic        Reset;
    logic [15:0] ADDR;
    logic        CE, OE, WE, UB, LB;
    tri1  [15:0] Data2;
    tri1  [15:0] Data0;
    logic        R2, Busy2, R0, Busy0;
    logic        drv;
    logic [15:0] dval;

    int n_chk  = 0;
    int n_fail = 0;

    logic [15:0] m2 [256];
    logic [15:0] m0 [256];

    assign Data2 = drv ? dval : 16'hzzzz;
    assign Data0 = drv ? dval : 16'hzzzz;

    sram_responder #(.ADDR_W(8), .WAIT_STATES(2)) dut2 (
        .Clk(Clk), .Reset(Reset), .ADDR(ADDR), .Data(Data2),
        .CE(CE), .OE(OE), .WE(WE), .UB(UB), .LB(LB),
        .R(R2), .Busy(Busy2)
    );

    sram_responder #(.ADDR_W(8), .WAIT_STATES(0)) dut0 (
        .Clk(Clk), .Reset(Reset), .ADDR(ADDR), .Data(Data0),
        .CE(CE), .OE(OE), .WE(WE), .UB(UB), .LB(LB),
        .R(R0), .Busy(Busy0)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string nm, input logic [15:0] act,
                       input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] lanes(input logic [15:0] w,
                                          input bit ub, input bit lb);
        return {ub ? 8'h00 : w[15:8], lb ? 8'h00 : w[7:0]};
    endfunction

    function automatic logic [15:0] merge(input logic [15:0] old,
                                          input logic [15:0] wd,
                                          input bit ub, input bit lb);
        return {ub ? old[15:8] : wd[15:8], lb ? old[7:0] : wd[7:0]};
    endfunction

    // One complete access; release is sampled at the 5th edge after T0.
    task automatic access(input bit wr, input bit both, input logic [15:0] a,
                          input bit ub, input bit lb, input logic [15:0] wd,
                          output logic [15:0] rd2, output logic [15:0] rd0);
        rd2 = 16'h0;
        rd0 = 16'h0;
        @(negedge Clk);
        ADDR = a;
        UB   = ub;
        LB   = lb;
        WE   = !wr;
        OE   = wr ? !both : 1'b0;
        CE   = 1'b0;
        drv  = wr;
        dval = wd;
        @(posedge Clk);
        for (int k = 0; k < 6; k++) begin
            #1;
            chk("R_ws2", R2, 16'(k == 2));
            chk("R_ws0", R0, 16'(k == 0));
            chk("Busy_ws2", Busy2, 16'(k < 5));
            chk("Busy_ws0", Busy0, 16'(k < 5));
            if (R2) rd2 = Data2;
            if (R0) rd0 = Data0;
            if ((wr && k > 0) || k == 5) begin
                chk("hiz_ws2", Data2, 16'hFFFF);
                chk("hiz_ws0", Data0, 16'hFFFF);
            end else if (!wr && k < 2) begin
                chk("rd_early_hiz_ws2", Data2, 16'hFFFF);
            end else if (!wr && k == 4) begin
                chk("rd_hold_ws2", Data2, rd2);
                chk("rd_hold_ws0", Data0, rd0);
            end
            if (k < 5) begin
                @(negedge Clk);
                drv  = 1'b0;
                ADDR = 16'($urandom);
                UB   = 1'($urandom);
                LB   = 1'($urandom);
                if (k == 4) begin
                    CE = 1'b1;
                    OE = 1'b1;
                    WE = 1'b1;
                end
                @(posedge Clk);
            end
        end
        if (wr) begin
            m2[a[7:0]] = merge(m2[a[7:0]], wd, ub, lb);
            m0[a[7:0]] = merge(m0[a[7:0]], wd, ub, lb);
        end
    endtask

    typedef struct {
        bit          wr;
        logic [15:0] a;
        bit          ub;
        bit          lb;
        logic [15:0] wd;
        logic [15:0] exp;
    } vec_t;

    vec_t tbl [6];

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] r2, r0, a;
        bit          wr, ub, lb;
        logic [15:0] wd;

        tbl[0] = '{1'b1, 16'h0012, 1'b0, 1'b0, 16'hBEEF, 16'h0000};
        tbl[1] = '{1'b0, 16'h0012, 1'b0, 1'b0, 16'h0000, 16'hBEEF};
        tbl[2] = '{1'b1, 16'h0012, 1'b0, 1'b1, 16'h12AA, 16'h0000};
        tbl[3] = '{1'b0, 16'h0012, 1'b0, 1'b0, 16'h0000, 16'h12EF};
        tbl[4] = '{1'b0, 16'h0012, 1'b1, 1'b0, 16'h0000, 16'h00EF};
        tbl[5] = '{1'b0, 16'h0112, 1'b0, 1'b0, 16'h0000, 16'h12EF};

        Reset = 1'b0;
        CE = 1'b1; OE = 1'b1; WE = 1'b1; UB = 1'b1; LB = 1'b1;
        ADDR = 16'h0; drv = 1'b0; dval = 16'h0;
        repeat (2) @(posedge Clk);
        #1;
        chk("rst_R_ws2", R2, 16'h0);
        chk("rst_Busy_ws2", Busy2, 16'h0);
        chk("rst_hiz_ws2", Data2, 16'hFFFF);
        chk("rst_R_ws0", R0, 16'h0);
        chk("rst_Busy_ws0", Busy0, 16'h0);
        chk("rst_hiz_ws0", Data0, 16'hFFFF);
        @(negedge Clk);
        Reset = 1'b1;

        for (int i = 0; i < 6; i++) begin
            access(tbl[i].wr, 1'b0, tbl[i].a, tbl[i].ub, tbl[i].lb,
                   tbl[i].wd, r2, r0);
            if (!tbl[i].wr) begin
                chk($sformatf("tbl%0d_rd_ws2", i), r2, tbl[i].exp);
                chk($sformatf("tbl%0d_rd_ws0", i), r0, tbl[i].exp);
            end
        end

        // Write aborted by CE in the first wait cycle; zero-wait copy commits.
        @(negedge Clk);
        ADDR = 16'h0012; UB = 1'b0; LB = 1'b0;
        WE = 1'b0; OE = 1'b1; CE = 1'b0;
        drv = 1'b1; dval = 16'h0000;
        @(posedge Clk);
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("abort_R_ws2", R2, 16'h0);
            chk("abort_R_ws0", R0, 16'(k == 0));
            chk("abort_Busy_ws2", Busy2, 16'(k == 0));
            chk("abort_Busy_ws0", Busy0, 16'(k == 0));
            @(negedge Clk);
            drv = 1'b0;
            CE  = 1'b1;
            @(posedge Clk);
        end
        WE = 1'b1;
        m0[8'h12] = 16'h0000;
        access(1'b0, 1'b0, 16'h0012, 1'b0, 1'b0, 16'h0, r2, r0);
        chk("abort_rd_ws2", r2, 16'h12EF);
        chk("abort_rd_ws0", r0, lanes(m0[8'h12], 1'b0, 1'b0));

        access(1'b1, 1'b1, 16'h0030, 1'b0, 1'b0, 16'h5555, r2, r0);
        access(1'b0, 1'b0, 16'h0030, 1'b0, 1'b0, 16'h0, r2, r0);
        chk("bothlow_rd_ws2", r2, 16'h5555);
        chk("bothlow_rd_ws0", r0, 16'h5555);

        // Reset while both copies are returning read data.
        @(negedge Clk);
        ADDR = 16'h0012; UB = 1'b0; LB = 1'b0;
        WE = 1'b1; OE = 1'b0; CE = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        chk("pre_rst_R_ws2", R2, 16'h1);
        #2;
        Reset = 1'b0;
        #1;
        chk("rdrst_hiz_ws2", Data2, 16'hFFFF);
        chk("rdrst_R_ws2", R2, 16'h0);
        chk("rdrst_Busy_ws2", Busy2, 16'h0);
        chk("rdrst_hiz_ws0", Data0, 16'hFFFF);
        chk("rdrst_R_ws0", R0, 16'h0);
        chk("rdrst_Busy_ws0", Busy0, 16'h0);
        OE = 1'b1; CE = 1'b1;
        @(negedge Clk);
        Reset = 1'b1;
        access(1'b0, 1'b0, 16'h0012, 1'b0, 1'b0, 16'h0, r2, r0);
        chk("rdrst_mem_ws2", r2, 16'h12EF);
        chk("rdrst_mem_ws0", r0, lanes(m0[8'h12], 1'b0, 1'b0));

        // Reset during the wait phase of a write must not commit it.
        @(negedge Clk);
        ADDR = 16'h0012; UB = 1'b0; LB = 1'b0;
        WE = 1'b0; OE = 1'b1; CE = 1'b0;
        drv = 1'b1; dval = 16'h7777;
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        drv = 1'b0; WE = 1'b1; CE = 1'b1;
        @(posedge Clk);
        #1;
        chk("wrrst_Busy_ws2", Busy2, 16'h0);
        @(negedge Clk);
        Reset = 1'b1;
        access(1'b0, 1'b0, 16'h0012, 1'b0, 1'b0, 16'h0, r2, r0);
        chk("wrrst_mem_ws2", r2, 16'h12EF);
        chk("wrrst_mem_ws0", r0, lanes(m0[8'h12], 1'b0, 1'b0));

        for (int i = 0; i < 8; i++) begin
            a = {8'($urandom), 8'h80 + 8'(i)};
            access(1'b1, 1'b0, a, 1'b0, 1'b0, 16'($urandom), r2, r0);
        end
        for (int i = 0; i < 40; i++) begin
            wr = 1'($urandom);
            ub = 1'($urandom);
            lb = 1'($urandom);
            wd = 16'($urandom);
            a  = {8'($urandom), 8'h80 + 8'($urandom_range(0, 7))};
            access(wr, 1'b0, a, ub, lb, wd, r2, r0);
            if (!wr) begin
                chk("rand_rd_ws2", r2, lanes(m2[a[7:0]], ub, lb));
                chk("rand_rd_ws0", r0, lanes(m0[a[7:0]], ub, lb));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
